// File: rtl/ysyx_23060203_ifu_fetch.sv
// Instruction fetch: one outstanding read, a one-entry instruction buffer,
// static next-pc prediction, and redirects that drop in-flight responses.
module ysyx_23060203_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_dnpc,
  input  logic        jump_flush,
  input  logic [31:0] jump_dnpc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] nxt;
  logic [31:0] inst;
  logic        discard;

  logic        redir;
  logic [31:0] target;
  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic        is_jal;
  logic        is_bneg;
  logic [31:0] pred;

  assign redir  = flush | jump_flush;
  assign target = flush ? flush_dnpc : jump_dnpc;

  assign imm_j = {{11{inst[31]}}, inst[31],
                  inst[19:12], inst[20],
                  inst[30:21], 1'b0};
  assign imm_b = {{19{inst[31]}}, inst[31],
                  inst[7], inst[30:25],
                  inst[11:8], 1'b0};

  assign is_jal  = inst[6:2] == 5'b11011;
  assign is_bneg = (inst[6:2] == 5'b11000)
                 & inst[31];

  // Backward branches predicted taken.
  always_comb begin
    pred = pc + 32'd4;
    unique case (1'b1)
      is_jal:  pred = pc + imm_j;
      is_bneg: pred = pc + imm_b;
      default: pred = pc + 32'd4;
    endcase
  end

  assign mem_req_valid = (state == S_REQ)
                       & ~reset;
  assign mem_req_addr  = pc;
  assign out_valid     = (state == S_FULL)
                       & ~redir;
  assign out_pc        = pc;
  assign out_inst      = inst;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      nxt     <= RESET_PC;
      inst    <= 32'd0;
      discard <= 1'b0;
    end else begin
      unique case (state)
        S_REQ: begin
          // Address stays put; the redirect lands
          // once the stale response is dropped.
          if (redir) begin
            discard <= 1'b1;
            nxt     <= target;
          end
          if (mem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            if (redir | discard) begin
              pc      <= redir ? target : nxt;
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              inst  <= mem_rsp_data;
              state <= S_FULL;
            end
          end else if (redir) begin
            discard <= 1'b1;
            nxt     <= target;
          end
        end
        S_FULL: begin
          if (redir) begin
            pc    <= target;
            state <= S_REQ;
          end else if (out_ready) begin
            pc    <= pred;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060203_ifu_fetch.md
YSYX_23060203_IFU_FETCH -- requirements
Module: ysyx_23060203_ifu_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h3000_0000, fetch address after reset SHALL be provided.
REQ-002 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 flush  in  1  global pipeline flush (exception/mret/fence.i); flush_dnpc  in  32  its redirect target.
REQ-005 jump_flush  in  1  decode-stage mispredict redirect; jump_dnpc  in  32  its target, bit 0 already zero.
REQ-006 mem_req_valid  out  1; mem_req_ready  in  1; mem_req_addr  out  32 -- instruction read request channel.
REQ-007 mem_rsp_valid  in  1; mem_rsp_data  in  32 -- read response, always accepted, in request order.
REQ-008 out_valid  out  1; out_ready  in  1; out_pc  out  32; out_inst  out  32 -- to decode stage.

Function
REQ-009 States SHALL be REQ (request asserted), WAIT (one request outstanding), FULL (instruction buffered); at most one request outstanding.
REQ-010 REQ: mem_req_valid=1, mem_req_addr=pc; on mem_req_ready -> WAIT.
REQ-011 Once asserted, mem_req_valid and mem_req_addr SHALL stay stable until mem_req_ready, even on a redirect.
REQ-012 WAIT: on mem_rsp_valid, capture {pc, mem_rsp_data} into the buffer -> FULL; rsp-to-out_valid latency 1 cycle.
REQ-013 FULL: out_valid = ~flush & ~jump_flush; out_pc/out_inst = buffered values; on out_valid & out_ready -> REQ with pc = predicted next pc.
REQ-014 Next-pc prediction from buffered inst: opcode[6:2]=11011 (JAL) -> pc+imm_j; opcode[6:2]=11000 (BRANCH) with inst[31]=1 -> pc+imm_b; all else (incl. JALR, BRANCH with inst[31]=0) -> pc+4.
REQ-015 imm_j = sext{inst[31],inst[19:12],inst[20],inst[30:21],0}; imm_b = sext{inst[31],inst[7],inst[30:25],inst[11:8],0}; adds modulo 2^32.
REQ-016 Redirect: flush takes priority over jump_flush; target = flush ? flush_dnpc : jump_dnpc; pc <= target.
REQ-017 Redirect in FULL: buffered instruction discarded -> REQ; no handshake that cycle.
REQ-018 Redirect in WAIT: set discard flag; matching response dropped (not buffered) -> REQ; response in same cycle as redirect also dropped.
REQ-019 Redirect in REQ: if request accepted same cycle or still pending, set discard and keep old address per REQ-011; its response dropped, then REQ with new pc.
REQ-020 Later redirect while discard set SHALL only update pc; exactly one response discarded.
REQ-021 Back-to-back redirects SHALL leave pc = most recent target.
REQ-022 mem_rsp_valid outside WAIT SHALL be ignored (protocol error, no state change).

Reset
REQ-023 On reset: state REQ, pc=RESET_PC, discard=0, buffer invalid.
REQ-024 Outputs during reset cycle: out_valid=0, mem_req_valid=0; first request cycle after reset deassertion, addr RESET_PC.
REQ-025 Reset mid-transaction SHALL abandon the outstanding request; environment guarantees no stale response after reset.

Verification
REQ-026 Reset, mem_req_ready=1, rsp 1 cycle later data 32'h00000013 -> out_valid with out_pc=32'h3000_0000; after handshake next addr 32'h3000_0004.
REQ-027 pc 32'h3000_0010, inst 32'hFE000EE3 (beq x0,x0,-4) -> next addr 32'h3000_000C; inst 32'h0080006F (jal +8) -> 32'h3000_0018.
REQ-028 In WAIT, jump_flush=1 jump_dnpc=32'h3000_0100, rsp arrives 3 cycles later -> rsp dropped, no out_valid, next addr 32'h3000_0100.
REQ-029 FULL with out_ready=1 and jump_flush=1 same cycle -> out_valid=0, buffer dropped, next addr = jump_dnpc.
REQ-030 flush (dnpc 32'h3000_0200) and jump_flush (dnpc 32'h3000_0300) same cycle -> next addr 32'h3000_0200.
REQ-031 mem_req_ready held 0 for 5 cycles with flush in cycle 2 -> addr stable at old pc until accepted, response dropped, then addr = flush_dnpc.
